// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for the EX stage (DIV / DIVU).
// Produces {remainder, quotient} for HI/LO; one operation at a time, one
// quotient bit per cycle. The operation can be annulled while it is in flight.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active-low
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        S_FREE    = 2'b00,
        S_BY_ZERO = 2'b01,
        S_ON      = 2'b10,
        S_END     = 2'b11
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dividend;   // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0]   r_divisor;    // divisor magnitude
    logic [WIDTH-1:0]   r_rem;        // partial remainder
    logic               r_quo_neg;
    logic               r_rem_neg;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    // Operand magnitudes and sign flags, only meaningful for DIV.
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [WIDTH-1:0]   w_op1_mag;
    logic [WIDTH-1:0]   w_op2_mag;

    assign w_op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign w_op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign w_op1_mag = w_op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_op2_mag = w_op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step: shift {rem, dividend} left, trial-subtract divisor.
    logic [WIDTH:0]     w_trial;
    logic [WIDTH+1:0]   w_diff;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_rem_next;

    assign w_trial    = {r_rem, r_dividend[WIDTH-1]};
    assign w_diff     = {1'b0, w_trial} - {2'b00, r_divisor};
    // The top two bits are both zero exactly when the difference is non-negative
    // (a non-negative difference is below the divisor, so it fits in WIDTH bits).
    assign w_q_bit    = (w_diff[WIDTH+1:WIDTH] == 2'b00);
    assign w_rem_next = w_q_bit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

    // Sign correction applied on the transition into END.
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_quo_fix = r_quo_neg ? (~r_dividend + 1'b1) : r_dividend;
    assign w_rem_fix = r_rem_neg ? (~r_rem + 1'b1)      : r_rem;

    // Control FSM and datapath registers with registered result/ready.
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FREE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo_neg  <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= S_BY_ZERO;
                        end else begin
                            r_state    <= S_ON;
                            r_dividend <= w_op1_mag;
                            r_divisor  <= w_op2_mag;
                            r_rem      <= '0;
                            r_cnt      <= '0;
                            r_quo_neg  <= w_op1_neg ^ w_op2_neg;
                            r_rem_neg  <= w_op1_neg;
                        end
                    end
                end
                S_BY_ZERO: begin
                    r_result <= '0;
                    if (annul_i) begin
                        r_state <= S_FREE;
                        r_ready <= 1'b0;
                    end else begin
                        r_state <= S_END;
                        r_ready <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        r_state  <= S_FREE;
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else if (r_cnt == CNT_W'(WIDTH)) begin
                        r_state  <= S_END;
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                    end else begin
                        r_rem      <= w_rem_next;
                        r_dividend <= {r_dividend[WIDTH-2:0], w_q_bit};
                        r_cnt      <= r_cnt + 1'b1;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        r_state  <= S_FREE;
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_FREE;
                    r_result <= '0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    // Stall request covers the request cycle and the whole computation.
    always_comb begin
        busy_o = 1'b0;
        case (r_state)
            S_ON, S_BY_ZERO: busy_o = 1'b1;
            S_FREE:          busy_o = start_i & ~annul_i;
            default:         busy_o = 1'b0;
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against a plain
// arithmetic reference model (64-bit division, truncation toward zero).
module tb_div_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic              annul_i = 1'b0;
    logic              signed_div_i = 1'b0;
    logic [WIDTH-1:0]  opdata1_i = '0;
    logic [WIDTH-1:0]  opdata2_i = '0;
    logic [2*WIDTH-1:0] result_o;
    logic              ready_o;
    logic              busy_o;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient}; zero divisor gives 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Runs one division starting at a negedge; returns at a negedge with start_i low
    // for exactly one elapsed edge, so consecutive calls are back-to-back.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
        int          edges;
        bit          busy_ok;
        logic [63:0] exp;
        exp          = ref_div(a, b, sgn);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        #1;
        check({tag, " req_busy"}, 64'(busy_o), 64'd1);
        @(posedge clk);
        #1;
        // Operands must be ignored once latched.
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        @(negedge clk);
        edges   = 1;
        busy_ok = 1'b1;
        while (!ready_o && edges < 60) begin
            if (!busy_o) busy_ok = 1'b0;
            @(negedge clk);
            edges++;
        end
        check({tag, " latency"}, 64'(edges), (b == 32'd0) ? 64'd2 : 64'd34);
        check({tag, " busy_hold"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_at_ready"}, 64'(busy_o), 64'd0);
        check({tag, " result"}, result_o, exp);
        // Hold in END with a stray annul: nothing may change.
        annul_i = 1'b1;
        @(negedge clk);
        check({tag, " end_hold"}, {63'(0), ready_o} ^ result_o, {63'(0), 1'b1} ^ exp);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check({tag, " release"}, result_o | 64'(ready_o), 64'd0);
    endtask

    initial begin
        int edges;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_result", result_o, 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy_o), 64'd0);

        // Directed operations.
        run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
        run_div(-32'sd7, 32'd2, 1'b1, "div_m7_2");
        run_div(32'd7, -32'sd2, 1'b1, "div_7_m2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_min_m1");
        run_div(32'd5, 32'd0, 1'b1, "div_by0");
        check("model_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h0000_0002_0000_000E);

        // Annul at cnt=10 (after edge 11).
        opdata1_i    = 32'hFFFF_FFFF;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        check("annul_busy", 64'(busy_o), 64'd0);
        check("annul_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        edges   = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) edges++;
        end
        check("annul_no_ready", 64'(edges), 64'd0);
        run_div(32'd9, 32'd3, 1'b0, "divu_9_3");

        // Asynchronous reset mid-operation at cnt=20.
        opdata1_i = 32'h1234_5678;
        opdata2_i = 32'h11;
        start_i   = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy_o), 64'd0);
        check("async_rst_out", result_o | 64'(ready_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 64'({busy_o, ready_o}), 64'd0);

        // Asynchronous reset while a result is being held.
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd9;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        edges        = 0;
        @(negedge clk);
        while (!ready_o && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        check("end_result", result_o, ref_div(32'd1000, 32'd9, 1'b0));
        #2 rst = 1'b0;
        #1;
        check("end_rst_out", result_o | 64'(ready_o), 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back followed by randomized operations (each call is back-to-back).
        run_div(32'd50, 32'd5, 1'b0, "b2b_1");
        run_div(-32'sd50, 32'd6, 1'b1, "b2b_2");
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_div(a, b, s, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
